// File: rtl/store_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : store_checker_if
// Description : Configuration, observed-store and verdict signals of store_checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_checker_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int N  = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic          start;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_adr;
    logic [DW-1:0] cfg_data;
    logic          MemWrite;
    logic [AW-1:0] Adr;
    logic [DW-1:0] WriteData;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [CW-1:0] match_cnt;
    logic [AW-1:0] bad_adr;
    logic [DW-1:0] bad_data;
    logic [31:0]   cyc_cnt;

    modport master (
        output start, cfg_we, cfg_idx, cfg_adr, cfg_data, MemWrite, Adr, WriteData,
        input  done, pass, fail_code, match_cnt, bad_adr, bad_data, cyc_cnt
    );

    modport slave (
        input  start, cfg_we, cfg_idx, cfg_adr, cfg_data, MemWrite, Adr, WriteData,
        output done, pass, fail_code, match_cnt, bad_adr, bad_data, cyc_cnt
    );
endinterface
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// ============================================================================
// Module      : store_checker
// Description : Checks data-memory stores against a table of N expected
//               (address, data) pairs, with ordered/unordered match and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module store_checker #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 4096,
    parameter int ORDERED = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    store_checker_if.slave bus
);
    localparam int            IW         = (N > 1) ? $clog2(N) : 1;
    localparam int            CW         = $clog2(N + 1);
    localparam logic [CW-1:0] c_n_entry  = CW'(N);
    localparam logic [1:0]    c_code_ok  = 2'b00;
    localparam logic [1:0]    c_code_mis = 2'b01;
    localparam logic [1:0]    c_code_to  = 2'b10;
    localparam logic [1:0]    c_code_ooo = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] tbl_adr_q  [N];
    logic [DW-1:0] tbl_data_q [N];
    logic [N-1:0]  matched_q, matched_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic [31:0]   cyc_cnt_q, cyc_cnt_d;
    logic [1:0]    fail_code_q, fail_code_d;
    logic [AW-1:0] bad_adr_q, bad_adr_d;
    logic [DW-1:0] bad_data_q, bad_data_d;

    logic          cfg_ok;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel_idx;
    logic          sel_hit;
    logic          ooo_hit;
    logic          data_ok;
    logic [31:0]   cyc_inc;

    assign cfg_ok = bus.cfg_we && (state_q != S_ARMED)
                 && ({1'b0, bus.cfg_idx} < (IW + 1)'(N));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                tbl_adr_q[i]  <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            tbl_adr_q[bus.cfg_idx]  <= bus.cfg_adr;
            tbl_data_q[bus.cfg_idx] <= bus.cfg_data;
        end
    end

    // Candidate entry for the observed address; ordered mode only looks at ptr.
    always_comb begin
        ptr     = match_cnt_q[IW-1:0];
        sel_hit = 1'b0;
        sel_idx = '0;
        ooo_hit = 1'b0;
        if (ORDERED != 0) begin
            sel_idx = ptr;
            sel_hit = (tbl_adr_q[ptr] == bus.Adr);
            for (int i = 0; i < N; i++) begin
                if ((i != int'(ptr)) && !matched_q[i] && (tbl_adr_q[i] == bus.Adr))
                    ooo_hit = 1'b1;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (!matched_q[i] && (tbl_adr_q[i] == bus.Adr)) begin
                    sel_hit = 1'b1;
                    sel_idx = IW'(i);
                end
            end
        end
        data_ok = (tbl_data_q[sel_idx] == bus.WriteData);
    end

    always_comb begin
        state_d     = state_q;
        matched_d   = matched_q;
        match_cnt_d = match_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        fail_code_d = fail_code_q;
        bad_adr_d   = bad_adr_q;
        bad_data_d  = bad_data_q;
        cyc_inc     = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + 32'd1;

        if (bus.start) begin
            state_d     = S_ARMED;
            matched_d   = '0;
            match_cnt_d = '0;
            cyc_cnt_d   = '0;
            fail_code_d = c_code_ok;
            bad_adr_d   = '0;
            bad_data_d  = '0;
        end else if (state_q == S_ARMED) begin
            cyc_cnt_d = cyc_inc;
            if (bus.MemWrite && sel_hit) begin
                if (data_ok) begin
                    matched_d[sel_idx] = 1'b1;
                    match_cnt_d        = match_cnt_q + 1'b1;
                    if (match_cnt_d == c_n_entry)
                        state_d = S_PASS;
                end else begin
                    state_d     = S_FAIL;
                    fail_code_d = c_code_mis;
                    bad_adr_d   = bus.Adr;
                    bad_data_d  = bus.WriteData;
                end
            end else if (bus.MemWrite && ooo_hit) begin
                state_d     = S_FAIL;
                fail_code_d = c_code_ooo;
                bad_adr_d   = bus.Adr;
                bad_data_d  = bus.WriteData;
            end
            // Watchdog loses to a final match or a data mismatch on the same edge.
            if ((state_d == S_ARMED) && (TIMEOUT != 0) && (cyc_inc == 32'(TIMEOUT))) begin
                state_d     = S_FAIL;
                fail_code_d = c_code_to;
                bad_adr_d   = '0;
                bad_data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            matched_q   <= '0;
            match_cnt_q <= '0;
            cyc_cnt_q   <= '0;
            fail_code_q <= c_code_ok;
            bad_adr_q   <= '0;
            bad_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            matched_q   <= matched_d;
            match_cnt_q <= match_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            fail_code_q <= fail_code_d;
            bad_adr_q   <= bad_adr_d;
            bad_data_q  <= bad_data_d;
        end
    end

    assign bus.done      = (state_q == S_PASS) || (state_q == S_FAIL);
    assign bus.pass      = (state_q == S_PASS);
    assign bus.fail_code = fail_code_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.bad_adr   = bad_adr_q;
    assign bus.bad_data  = bad_data_q;
    assign bus.cyc_cnt   = cyc_cnt_q;
endmodule
`default_nettype wire

// File: doc/store_checker.md
# store_checker

Parametrised, synthesizable bus monitor that watches the processor's data-memory write port and checks it against a programmed table of N expected stores (address, data). It reports pass/fail with a cause code, the offending address and data, a match count and an elapsed-cycle count. It sits beside `top` in the multicycle-core benches and also on FPGA builds for board self-test. It generalises the single-store, single-address end-of-program check to N entries, ordered or unordered matching, and a watchdog timeout.

## Interface
- DW, 32, data width of WriteData and table data
- AW, 32, address width of Adr and table addresses
- N, 4, number of expected stores (1..16); IW = max(1, clog2(N))
- TIMEOUT, 4096, cycles allowed in ARMED before a timeout fail; 0 disables the watchdog
- ORDERED, 1, 1 = entries must match in index order; 0 = any order

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle pulse; arms checker, clears results
- cfg_we  in  1  table write strobe
- cfg_idx  in  IW  table entry index
- cfg_adr  in  AW  expected address
- cfg_data  in  DW  expected data
- MemWrite  in  1  observed store strobe
- Adr  in  AW  observed store address
- WriteData  in  DW  observed store data
- done  out  1  verdict reached (PASS or FAIL)
- pass  out  1  all N entries matched
- fail_code  out  2  00 none, 01 data mismatch, 10 timeout, 11 out-of-order
- match_cnt  out  clog2(N+1)  entries matched so far
- bad_adr  out  AW  address of failing store (0 for timeout)
- bad_data  out  DW  data of failing store (0 for timeout)
- cyc_cnt  out  32  cycles spent in ARMED, saturating

## Operation
- Reset (reset=0): state IDLE; done=0, pass=0, fail_code=00, match_cnt=0, bad_adr=0, bad_data=0, cyc_cnt=0. All table entries and matched bits are cleared to 0.
- States: IDLE, ARMED, PASS, FAIL.
- Table writes: cfg_we writes entry cfg_idx. Writes are accepted only in IDLE, PASS and FAIL; they are ignored in ARMED. Writes with cfg_idx ≥ N are ignored.
- start from any state: go to ARMED; clear matched bits, match_cnt, cyc_cnt, fail_code, bad_adr, bad_data, done and pass. start in ARMED restarts the check.
- cfg_we and start in the same cycle: the write lands and the checker arms. Comparison begins the next cycle, so it uses the new entry.
- ARMED, ORDERED=1, with ptr = match_cnt, on each cycle where MemWrite=1:
  - Adr==adr[ptr] and WriteData==data[ptr]: match_cnt increments.
  - Adr==adr[ptr] and data differs: FAIL, code 01.
  - Adr equals any other unmatched entry's address: FAIL, code 11.
  - Otherwise the store is ignored.
- ARMED, ORDERED=0: select the lowest-index unmatched entry whose address equals Adr.
  - Data equal: set its matched bit and increment match_cnt.
  - Data differs: FAIL, code 01.
  - No unmatched entry has that address: the store is ignored. Stores to already-matched addresses are ignored.
- match_cnt reaching N: go to PASS with done=1, pass=1.
- Watchdog: cyc_cnt increments on every ARMED cycle. When TIMEOUT≠0 and cyc_cnt reaches TIMEOUT, go to FAIL with code 10.
- On any FAIL: latch bad_adr and bad_data from the failing store; set done=1, pass=0.
- PASS and FAIL are sticky until start or reset. Bus activity is ignored there, and cyc_cnt holds its value.

## Timing
- MemWrite, Adr and WriteData are sampled on the rising edge and have no handshake back to the core.
- A store sampled at edge k updates match_cnt, state and all outputs at edge k. Verdict latency is therefore 1 cycle from the store being presented.
- start sampled at edge k: ARMED from edge k. The first cycle counted and the first store compared are those sampled at edge k+1.
- Timeout: FAIL is entered at the edge on which cyc_cnt becomes TIMEOUT, i.e. the TIMEOUT-th ARMED cycle.
- Final match and timeout at the same edge: the match wins and the checker goes to PASS.
- Mismatch and timeout at the same edge: the result is code 01.
- Reset asserted mid-ARMED: all outputs go to their reset values immediately (asynchronous). After release the checker stays in IDLE with an empty table.
- cyc_cnt saturates at 2^32−1.

## Test plan
- N=1, entry0=(160, 0x28); start; stores (100, 5) then (160, 0x28) -> one cycle after the second store: done=1, pass=1, match_cnt=1, fail_code=00.
- Same setup; store (160, 0x27) -> done=1, pass=0, fail_code=01, bad_adr=160, bad_data=0x27.
- TIMEOUT=50; only non-table stores -> fail_code=10 when cyc_cnt=50, bad_adr=0; TIMEOUT=0 -> still ARMED after 10000 cycles.
- N=2 entries (160, 0x28) and (164, 0x3); stores 164 then 160:
  - ORDERED=1 -> fail_code=11, bad_adr=164.
  - ORDERED=0 -> pass=1, match_cnt=2.
- TIMEOUT=20; last matching store sampled on the 20th ARMED cycle -> pass=1, fail_code=00. cfg_we in ARMED -> table unchanged.
- Reset low mid-ARMED with match_cnt=1 -> all outputs 0 immediately. After release, start with no reprogramming and a store (0, 0) -> matches the cleared entries.
